dmem_arbiter: RTL

// Two-port arbiter and sequencer for the single-port 32x16 data memory.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 32x16 data memory between the core
// load/store port (C) and the loader/DMA port (D). One access at a time.
//
// Handshake: a port raises req with we/addr/wdata and keeps all of them stable
// until it sees its one-cycle gnt pulse. The pulse marks the cycle the access
// is issued. After that the port may drop or change req. Reads complete later
// with a one-cycle rvalid pulse. The read data stays in rdata until that
// port's next read completes.
module dmem_arbiter #(
  parameter int RD_LAT    = 1,    // cycles from access to valid mem_rdata (0..3)
  parameter bit FIXED_PRI = 1'b0  // 0: round-robin ties, 1: port C wins ties
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [4:0]  c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [15:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [4:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [4:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   WAIT_LOAD_INT = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [1:0] WAIT_LOAD = 2'(WAIT_LOAD_INT);

  state_t      state;
  state_t      state_nx;
  logic        lat_we;
  logic [4:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_port;
  logic        last_winner;
  logic [1:0]  wait_cnt;
  logic        pick_d;
  logic        sample_rd;

  // Arbitration: a lone requester wins; ties go by priority mode.
  always_comb begin
    pick_d = 1'b0;
    if (c_req && d_req) begin
      pick_d = FIXED_PRI ? 1'b0 : (last_winner == PORT_C);
    end else begin
      pick_d = d_req;
    end
  end

  // Next-state decode for the access sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (c_req || d_req) state_nx = ACCESS;
      ACCESS: begin
        if (lat_we)           state_nx = IDLE;
        else if (RD_LAT == 0) state_nx = RESP;
        else                  state_nx = WAIT;
      end
      WAIT:    if (wait_cnt == 2'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Latch the winning request when leaving IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 5'd0;
      lat_wdata <= 16'd0;
      lat_port  <= PORT_C;
    end else if (state == IDLE && (c_req || d_req)) begin
      lat_port  <= pick_d;
      lat_we    <= pick_d ? d_we    : c_we;
      lat_addr  <= pick_d ? d_addr  : c_addr;
      lat_wdata <= pick_d ? d_wdata : c_wdata;
    end
  end

  // Remember who was served last; reset to D so C takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                last_winner <= PORT_D;
    else if (state == ACCESS)  last_winner <= lat_port;
  end

  // Read-latency counter: loads RD_LAT-1 in ACCESS, counts down to 0 in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  wait_cnt <= 2'd0;
    else if (state == ACCESS)                    wait_cnt <= WAIT_LOAD;
    else if (state == WAIT && wait_cnt != 2'd0)  wait_cnt <= wait_cnt - 2'd1;
  end

  assign sample_rd = !lat_we &&
                     (((RD_LAT == 0) && (state == ACCESS)) ||
                      ((RD_LAT != 0) && (state == WAIT) && (wait_cnt == 2'd0)));

  // Capture read data into the winner's holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rdata <= 16'd0;
      d_rdata <= 16'd0;
    end else if (sample_rd) begin
      if (lat_port == PORT_C) c_rdata <= mem_rdata;
      else                    d_rdata <= mem_rdata;
    end
  end

  // Outputs come only from state and the latch, so no req reaches mem_* combinationally.
  assign busy      = (state != IDLE);
  assign mem_addr  = (state == ACCESS || state == WAIT) ? lat_addr : 5'd0;
  assign mem_wdata = (state == ACCESS) ? lat_wdata : 16'd0;
  assign mem_write = (state == ACCESS) && lat_we;
  assign mem_read  = ((state == ACCESS) && !lat_we) || (state == WAIT);
  assign c_gnt     = (state == ACCESS) && (lat_port == PORT_C);
  assign d_gnt     = (state == ACCESS) && (lat_port == PORT_D);
  assign c_rvalid  = (state == RESP) && (lat_port == PORT_C);
  assign d_rvalid  = (state == RESP) && (lat_port == PORT_D);

endmodule
